// File: rtl/ex_mem_stage_if.sv
// EX/MEM stage bundle: EX-side entry offer plus MEM-side registered outputs.
// master = producer/consumer environment, slave = the pipeline stage itself.
interface ex_mem_stage_if #(parameter int DATA_W = 32);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] ALU_Result;
   logic              zero;
   logic [DATA_W-1:0] rs2_data;
   logic [4:0]        rd_addr;
   logic [DATA_W-1:0] br_target;
   logic              Branch;
   logic              MemRead;
   logic              MemWrite;
   logic              RegWrite;
   logic              MemtoReg;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_alu;
   logic [DATA_W-1:0] out_wdata;
   logic [DATA_W-1:0] out_target;
   logic [4:0]        out_rd;
   logic              out_MemRead;
   logic              out_MemWrite;
   logic              out_RegWrite;
   logic              out_MemtoReg;
   logic              branch_taken;
   logic [15:0]       stall_cnt;

   modport master (
      output in_valid, ALU_Result, zero, rs2_data, rd_addr, br_target,
             Branch, MemRead, MemWrite, RegWrite, MemtoReg, flush, out_ready,
      input  in_ready, out_valid, out_alu, out_wdata, out_target, out_rd,
             out_MemRead, out_MemWrite, out_RegWrite, out_MemtoReg,
             branch_taken, stall_cnt
   );

   modport slave (
      input  in_valid, ALU_Result, zero, rs2_data, rd_addr, br_target,
             Branch, MemRead, MemWrite, RegWrite, MemtoReg, flush, out_ready,
      output in_ready, out_valid, out_alu, out_wdata, out_target, out_rd,
             out_MemRead, out_MemWrite, out_RegWrite, out_MemtoReg,
             branch_taken, stall_cnt
   );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register built as a two-entry skid buffer so that in_ready
// depends only on registered state, never combinationally on out_ready.
module ex_mem_stage #(
   parameter int DATA_W = 32
) (
   input logic           clk,
   input logic           reset,
   ex_mem_stage_if.slave bus
);

   typedef struct packed {
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] wdata;
      logic [DATA_W-1:0] target;
      logic [4:0]        rd;
      logic              branch;
      logic              mem_read;
      logic              mem_write;
      logic              reg_write;
      logic              memto_reg;
      logic              zero;
   } entry_t;

   // Encoding mirrors (out_valid, skid_valid); (0,1) has no state.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b10,
      FULL  = 2'b11
   } state_t;

   state_t state;
   state_t next_state;
   entry_t out_q;
   entry_t skid_q;
   entry_t next_out;
   entry_t next_skid;
   entry_t in_entry;
   logic   out_valid;
   logic   skid_valid;
   logic   accept;
   logic   fire;

   assign in_entry = '{
      alu:       bus.ALU_Result,
      wdata:     bus.rs2_data,
      target:    bus.br_target,
      rd:        bus.rd_addr,
      branch:    bus.Branch,
      mem_read:  bus.MemRead,
      mem_write: bus.MemWrite,
      reg_write: bus.RegWrite,
      memto_reg: bus.MemtoReg,
      zero:      bus.zero
   };

   assign out_valid  = (state != EMPTY);
   assign skid_valid = (state == FULL);
   assign accept     = bus.in_valid & ~skid_valid;
   assign fire       = out_valid & bus.out_ready;

   // State and entry storage; reset clears entries so outputs read zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= EMPTY;
         out_q  <= '0;
         skid_q <= '0;
      end else begin
         state  <= next_state;
         out_q  <= next_out;
         skid_q <= next_skid;
      end
   end

   // Next-state and entry movement; flush only invalidates, data may linger.
   always_comb begin
      next_state = state;
      next_out   = out_q;
      next_skid  = skid_q;
      unique case (state)
         EMPTY: begin
            if (accept) begin
               next_out   = in_entry;
               next_state = ONE;
            end
         end
         ONE: begin
            if (accept && fire) begin
               next_out = in_entry;
            end else if (accept) begin
               next_skid  = in_entry;
               next_state = FULL;
            end else if (fire) begin
               next_state = EMPTY;
            end
         end
         FULL: begin
            if (fire) begin
               next_out   = skid_q;
               next_state = ONE;
            end
         end
         default: next_state = EMPTY;
      endcase
      if (bus.flush) begin
         next_state = EMPTY;
      end
   end

   // Count stalled output cycles, saturating; only reset clears it.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.stall_cnt <= '0;
      end else if (out_valid && !bus.out_ready && (bus.stall_cnt != 16'hFFFF)) begin
         bus.stall_cnt <= bus.stall_cnt + 16'd1;
      end
   end

   assign bus.in_ready     = ~skid_valid;
   assign bus.out_valid    = out_valid;
   assign bus.out_alu      = out_q.alu;
   assign bus.out_wdata    = out_q.wdata;
   assign bus.out_target   = out_q.target;
   assign bus.out_rd       = out_q.rd;
   assign bus.out_MemRead  = out_valid & out_q.mem_read;
   assign bus.out_MemWrite = out_valid & out_q.mem_write;
   assign bus.out_RegWrite = out_valid & out_q.reg_write;
   assign bus.out_MemtoReg = out_valid & out_q.memto_reg;
   assign bus.branch_taken = out_valid & out_q.branch & out_q.zero;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage against a queue-based FIFO model.
module tb_ex_mem_stage;

   typedef struct {
      logic [31:0] alu;
      logic [31:0] wdata;
      logic [31:0] target;
      logic [4:0]  rd;
      logic        br;
      logic        mr;
      logic        mw;
      logic        rw;
      logic        m2r;
      logic        z;
   } ent_t;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   ent_t q[$];
   int   expCnt;

   ex_mem_stage_if #(.DATA_W(32)) bus ();

   ex_mem_stage #(.DATA_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic ent_t randEntry();
      ent_t e;
      e.alu    = $urandom;
      e.wdata  = $urandom;
      e.target = $urandom;
      e.rd     = 5'($urandom);
      e.br     = 1'($urandom);
      e.mr     = 1'($urandom);
      e.mw     = 1'($urandom);
      e.rw     = 1'($urandom);
      e.m2r    = 1'($urandom);
      e.z      = 1'($urandom);
      return e;
   endfunction

   function automatic ent_t mkEntry(input logic [31:0] alu, input logic br,
                                    input logic z, input logic [31:0] tgt);
      ent_t e;
      e        = randEntry();
      e.alu    = alu;
      e.br     = br;
      e.z      = z;
      e.target = tgt;
      return e;
   endfunction

   task automatic checkOutput();
      bit v;
      v = (q.size() > 0);
      check("out_valid", 32'(bus.out_valid), 32'(v));
      check("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
      check("stall_cnt", 32'(bus.stall_cnt), 32'(expCnt));
      if (v) begin
         check("out_alu", bus.out_alu, q[0].alu);
         check("out_wdata", bus.out_wdata, q[0].wdata);
         check("out_target", bus.out_target, q[0].target);
         check("out_rd", 32'(bus.out_rd), 32'(q[0].rd));
         check("out_ctrl",
               32'({bus.out_MemRead, bus.out_MemWrite, bus.out_RegWrite, bus.out_MemtoReg}),
               32'({q[0].mr, q[0].mw, q[0].rw, q[0].m2r}));
         check("branch_taken", 32'(bus.branch_taken), 32'(q[0].br & q[0].z));
      end else begin
         check("idle_ctrl",
               32'({bus.out_MemRead, bus.out_MemWrite, bus.out_RegWrite, bus.branch_taken}), 32'd0);
      end
   endtask

   // Drive one cycle, advance the model at the edge, check at the falling edge.
   task automatic applyStimulus(input bit v, input bit ordy, input bit fl,
                                input bit rst, input ent_t e);
      bit acc;
      bit fir;
      reset          = rst;
      bus.flush      = fl;
      bus.in_valid   = v;
      bus.out_ready  = ordy;
      bus.ALU_Result = e.alu;
      bus.rs2_data   = e.wdata;
      bus.br_target  = e.target;
      bus.rd_addr    = e.rd;
      bus.Branch     = e.br;
      bus.MemRead    = e.mr;
      bus.MemWrite   = e.mw;
      bus.RegWrite   = e.rw;
      bus.MemtoReg   = e.m2r;
      bus.zero       = e.z;
      @(posedge clk);
      acc = v && (q.size() < 2);
      fir = (q.size() > 0) && ordy;
      if (rst) begin
         q.delete();
         expCnt = 0;
      end else begin
         if ((q.size() > 0) && !ordy && (expCnt < 16'hFFFF)) expCnt++;
         if (fl) begin
            q.delete();
         end else begin
            if (fir) void'(q.pop_front());
            if (acc) q.push_back(e);
         end
      end
      @(negedge clk);
      checkOutput();
   endtask

   task automatic checkResetValues();
      check("rst_alu", bus.out_alu, 32'd0);
      check("rst_wdata", bus.out_wdata, 32'd0);
      check("rst_target", bus.out_target, 32'd0);
      check("rst_rd", 32'(bus.out_rd), 32'd0);
      check("rst_memtoreg", 32'(bus.out_MemtoReg), 32'd0);
   endtask

   initial begin
      ent_t e;
      int   target;
      total  = 0;
      bad    = 0;
      expCnt = 0;
      e      = randEntry();

      // Reset with flush, in_valid and out_ready all asserted.
      applyStimulus(1, 1, 1, 1, e);
      applyStimulus(1, 1, 1, 1, e);
      checkResetValues();

      // Streaming 0x10, 0x20, 0x30 with out_ready high.
      applyStimulus(1, 1, 0, 0, mkEntry(32'h10, 0, 0, 32'h0));
      check("stream_first", bus.out_alu, 32'h10);
      applyStimulus(1, 1, 0, 0, mkEntry(32'h20, 0, 0, 32'h0));
      applyStimulus(1, 1, 0, 0, mkEntry(32'h30, 0, 0, 32'h0));
      check("stream_last", bus.out_alu, 32'h30);
      applyStimulus(0, 1, 0, 0, e);

      // Backpressure: 0xA then 0xB with out_ready low, then drain.
      applyStimulus(1, 0, 0, 0, mkEntry(32'hA, 0, 0, 32'h0));
      applyStimulus(1, 0, 0, 0, mkEntry(32'hB, 0, 0, 32'h0));
      check("bp_hold", bus.out_alu, 32'hA);
      check("bp_full", 32'(bus.in_ready), 32'd0);
      applyStimulus(1, 0, 0, 0, mkEntry(32'hC, 0, 0, 32'h0));
      applyStimulus(0, 1, 0, 0, e);
      check("bp_second", bus.out_alu, 32'hB);
      applyStimulus(0, 1, 0, 0, e);
      check("bp_stalls", 32'(bus.stall_cnt), 32'd2);

      // Branch taken, then zero clear.
      applyStimulus(1, 1, 0, 0, mkEntry(32'h1, 1, 1, 32'h0000_0100));
      check("br_taken", 32'(bus.branch_taken), 32'd1);
      check("br_target", bus.out_target, 32'h100);
      applyStimulus(1, 1, 0, 0, mkEntry(32'h2, 1, 0, 32'h0000_0100));
      check("br_not_taken", 32'(bus.branch_taken), 32'd0);
      applyStimulus(0, 1, 0, 0, e);

      // Flush while FULL with a new entry offered.
      applyStimulus(1, 0, 0, 0, randEntry());
      applyStimulus(1, 0, 0, 0, randEntry());
      applyStimulus(1, 0, 1, 0, randEntry());
      check("flush_empty", 32'(bus.out_valid), 32'd0);
      applyStimulus(0, 1, 0, 0, e);

      // Randomized traffic with occasional flush and reset.
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'($urandom), 1'($urandom), ($urandom_range(15) == 0),
                       ($urandom_range(63) == 0), randEntry());
      end

      // Reset while FULL overrides everything.
      applyStimulus(1, 0, 0, 0, randEntry());
      applyStimulus(1, 0, 0, 0, randEntry());
      applyStimulus(1, 0, 0, 0, randEntry());
      applyStimulus(1, 1, 1, 1, randEntry());
      checkResetValues();

      // Saturation: one entry held under backpressure for 70000 cycles.
      applyStimulus(1, 0, 0, 0, mkEntry(32'h55, 0, 0, 32'h0));
      reset         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.flush     = 1'b0;
      repeat (70000) @(posedge clk);
      target = expCnt + 70000;
      expCnt = (target > 65535) ? 65535 : target;
      @(negedge clk);
      checkOutput();
      check("sat_value", 32'(bus.stall_cnt), 32'hFFFF);
      applyStimulus(0, 0, 1, 0, e);
      check("sat_after_flush", 32'(bus.stall_cnt), 32'hFFFF);
      applyStimulus(1, 1, 1, 1, e);
      check("sat_reset", 32'(bus.stall_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter: DATA_W, 32, width of ALU result, store data and branch target.
REQ-002 SHALL have ports (clock and reset first); one clock, reset synchronous and active-high:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  EX entry offered.
- in_ready  out  1  stage accepts entry this cycle.
- ALU_Result  in  DATA_W  ALU output.
- zero  in  1  ALU zero flag.
- rs2_data  in  DATA_W  store data.
- rd_addr  in  5  destination register.
- br_target  in  DATA_W  precomputed PC+imm.
- Branch, MemRead, MemWrite, RegWrite, MemtoReg  in  1 each  control bits.
- flush  in  1  discard all held entries.
- out_valid  out  1  MEM entry valid.
- out_ready  in  1  MEM consumes entry.
- out_alu, out_wdata, out_target  out  DATA_W  registered copies.
- out_rd  out  5  registered rd_addr.
- out_MemRead, out_MemWrite, out_RegWrite, out_MemtoReg  out  1  registered controls.
- branch_taken  out  1  out_valid & out Branch & out zero.
- stall_cnt  out  16  cycles with out_valid=1 and out_ready=0.

Function
REQ-003 SHALL hold two entries: OUT (drives outputs) and SKID (overflow); each entry holds all data, control and zero bits plus a valid bit.
REQ-004 SHALL drive in_ready = !skid_valid, from registered state only (no combinational path from out_ready).
REQ-005 SHALL define accept = in_valid & in_ready and fire = out_valid & out_ready.
REQ-006 SHALL use states by (out_valid, skid_valid): EMPTY (0,0), ONE (1,0), FULL (1,1); (0,1) SHALL be unreachable.
REQ-007 EMPTY: accept -> load OUT, go ONE next cycle (latency 1 cycle input to output).
REQ-008 ONE: accept & fire -> OUT loads new entry, stay ONE; accept & !fire -> entry to SKID, go FULL; fire & !accept -> EMPTY; neither -> hold.
REQ-009 FULL: in_ready=0; fire -> SKID moves to OUT, SKID cleared, go ONE; !fire -> hold all.
REQ-010 SHALL keep OUT contents stable while out_valid=1 and out_ready=0.
REQ-011 SHALL preserve entry order; no entry dropped or duplicated except by flush/reset.
REQ-012 branch_taken SHALL be 0 whenever out_valid=0.
REQ-013 flush SHALL clear out_valid and skid_valid next cycle, overriding accept and fire in the same cycle; entry offered in flush cycle is discarded.
REQ-014 stall_cnt SHALL increment by 1 each cycle out_valid=1 and out_ready=0, saturate at 16'hFFFF, and not be cleared by flush.
REQ-015 Data fields of invalid entries are don't-care; control outputs (out_MemRead, out_MemWrite, out_RegWrite) SHALL read 0 when out_valid=0.

Reset
REQ-016 reset SHALL override flush, accept and fire in the same cycle.
REQ-017 On reset: out_valid=0, skid_valid=0, in_ready=1 next cycle, all out_* data=0, controls=0, branch_taken=0, stall_cnt=0.
REQ-018 Reset asserted mid-operation (FULL state) SHALL discard both entries, state EMPTY next cycle.

Verification
REQ-019 Streaming: out_ready=1, ALU_Result=0x10,0x20,0x30 on consecutive cycles -> out_alu 0x10,0x20,0x30 one cycle later each, in_ready stays 1.
REQ-020 Backpressure: out_ready=0, entries 0xA then 0xB -> in_ready=0 after second accept, out_alu=0xA held; out_ready=1 -> 0xA then 0xB, in_ready returns 1; stall_cnt equals stall cycles.
REQ-021 Branch: Branch=1, zero=1, br_target=0x0000_0100 -> branch_taken=1, out_target=0x100 for one output cycle; zero=0 -> branch_taken=0.
REQ-022 Flush in FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, no entry emerges.
REQ-023 reset with flush, in_valid and out_ready all 1 -> all outputs at reset values, stall_cnt=0.
REQ-024 Saturation: hold out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=0xFFFF, no wrap.
